// File: rtl/mod_74x08_2_pkg.sv
// Shared constants and helpers for the 74x08 glue-logic slice.
// Timing defaults mirror the 74xx library's common constants.
package mod_74x08_2_pkg;

    localparam int TPD_DEFAULT     = 0;
    localparam bit REG_OUT_DEFAULT = 1'b1;

    // Reset gates the output low regardless of the data inputs.
    function automatic logic and2_gated(input logic en, input logic a, input logic b);
        return en & a & b;
    endfunction

endpackage

// File: rtl/mod_74x08_2_and2_cell.sv
// Single 2-input AND with reset gating and an optional output flop.
// The combinational path never depends on clk.
module mod_74x08_2_and2_cell
    import mod_74x08_2_pkg::*;
#(
    parameter bit REG_OUT = REG_OUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic y,
    output logic yq
);

    assign y = and2_gated(rst_n, a, b);

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                yq <= 1'b0;
            end else begin
                yq <= y;
            end
        end
    end else begin : g_noreg
        logic unused_clk;
        assign unused_clk = clk;
        assign yq         = 1'b0;
    end

endmodule

// File: rtl/mod_74x08_2.sv
// Two independent reset-gated AND gates (half of a 74x08) with
// registered copies of each output for synchronous consumers.
module mod_74x08_2
    import mod_74x08_2_pkg::*;
#(
    parameter int TPD     = TPD_DEFAULT,
    parameter bit REG_OUT = REG_OUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A1,
    input  logic B1,
    input  logic A2,
    input  logic B2,
    output logic Y1,
    output logic Y2,
    output logic YQ1,
    output logic YQ2
);

    // Delay only matters to behavioural library models; the netlist is zero-delay.
    if (TPD < 0) begin : g_tpd_invalid
    end

    mod_74x08_2_and2_cell #(
        .REG_OUT (REG_OUT)
    ) u_gate1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (A1),
        .b     (B1),
        .y     (Y1),
        .yq    (YQ1)
    );

    mod_74x08_2_and2_cell #(
        .REG_OUT (REG_OUT)
    ) u_gate2 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (A2),
        .b     (B2),
        .y     (Y2),
        .yq    (YQ2)
    );

endmodule

// File: tb/tb_mod_74x08_2.sv
// Self-checking bench for mod_74x08_2: directed truth-table, reset and
// isolation cases, then randomized vectors against a truth-table model.
module tb_mod_74x08_2;

    logic clk;
    logic rst_n;
    logic A1, B1, A2, B2;
    logic Y1, Y2, YQ1, YQ2;

    int vectors;
    int miscompares;

    // AND truth table indexed by {a,b}: only 11 yields 1.
    logic [3:0] and_tt;

    mod_74x08_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A1    (A1),
        .B1    (B1),
        .A2    (A2),
        .B2    (B2),
        .Y1    (Y1),
        .Y2    (Y2),
        .YQ1   (YQ1),
        .YQ2   (YQ2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_y(input logic rst, input logic a, input logic b);
        logic [1:0] idx;
        if (!rst) return 1'b0;
        idx = {a, b};
        return and_tt[idx];
    endfunction

    task automatic drive(input logic a1, input logic b1, input logic a2, input logic b2);
        A1 = a1;
        B1 = b1;
        A2 = a2;
        B2 = b2;
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        logic       ey1, ey2;
        logic       hold;

        vectors     = 0;
        miscompares = 0;
        and_tt      = 4'b1000;

        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_y1", Y1, 1'b0);
        check("rst_y2", Y2, 1'b0);
        check("rst_yq1", YQ1, 1'b0);
        check("rst_yq2", YQ2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Gate 1 truth table, gate 2 held at 0.
        for (int i = 3; i >= 0; i--) begin
            pat = 4'(i);
            drive(pat[1], pat[0], 1'b0, 1'b0);
            check("g1_y1", Y1, model_y(1'b1, pat[1], pat[0]));
            check("g1_y2", Y2, 1'b0);
            #19;
        end

        // Gate 2 truth table, gate 1 held at 11 then left as is.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        hold = Y1;
        for (int i = 3; i >= 0; i--) begin
            pat = 4'(i);
            drive(1'b1, 1'b1, pat[1], pat[0]);
            check("g2_y2", Y2, model_y(1'b1, pat[1], pat[0]));
            check("g2_y1", Y1, 1'b1);
            #19;
        end
        check("g2_hold", hold, 1'b1);

        // Async reset without a clock edge, then release.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_y1", Y1, 1'b0);
        check("ar_y2", Y2, 1'b0);
        check("ar_yq1", YQ1, 1'b0);
        check("ar_yq2", YQ2, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_y1", Y1, 1'b1);
        check("rel_y2", Y2, 1'b1);
        check("rel_yq1", YQ1, 1'b0);

        // Registered latency of one rising edge.
        @(posedge clk);
        #1;
        check("lat_yq1_set", YQ1, 1'b1);
        check("lat_yq2_set", YQ2, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        check("lat_y1_drop", Y1, 1'b0);
        check("lat_yq1_hold", YQ1, 1'b1);
        @(posedge clk);
        #1;
        check("lat_yq1_clr", YQ1, 1'b0);
        check("lat_yq2_keep", YQ2, 1'b1);

        // Isolation: gate 2 sweeps while gate 1 stays at 11.
        for (int i = 0; i < 4; i++) begin
            pat = 4'(i);
            drive(1'b1, 1'b1, pat[1], pat[0]);
            check("iso_y1", Y1, 1'b1);
            check("iso_y2", Y2, model_y(1'b1, pat[1], pat[0]));
        end

        // A 0 on one input dominates an unknown on the other.
        drive(1'b0, 1'bx, 1'b0, 1'b0);
        check("x_dom_y1", Y1, 1'b0);

        // Randomized vectors with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            pat = 4'($urandom_range(0, 15));
            drive(pat[3], pat[2], pat[1], pat[0]);
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rnd_rst_y1", Y1, 1'b0);
                check("rnd_rst_yq1", YQ1, 1'b0);
                check("rnd_rst_yq2", YQ2, 1'b0);
                rst_n = 1'b1;
                #1;
            end
            ey1 = model_y(rst_n, pat[3], pat[2]);
            ey2 = model_y(rst_n, pat[1], pat[0]);
            check("rnd_y1", Y1, ey1);
            check("rnd_y2", Y2, ey2);
            @(posedge clk);
            #1;
            check("rnd_yq1", YQ1, ey1);
            check("rnd_yq2", YQ2, ey2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
